dm_cache_ctrl: RTL and testbench

Direct-mapped, write-through, write-allocate cache controller between the byte-addressed processor port (9-bit address, 8-bit data) and the 128 × 32-bit word RAM. It sequences tag lookup, line fill and write-through on the RAM port and signals completion with a one-cycle `dv` pulse. It replaces direct RAM reads in the memory-check top level; `p_rdata` feeds the BCD display path.

---
 rtl/dm_cache_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, write-allocate cache controller.
// 8 lines x one 32-bit word sit between a byte-addressed processor port
// (9-bit address, 8-bit data) and a 128 x 32-bit word RAM.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   p_req/p_wren/p_address/p_wdata : processor request, sampled while busy=0
//   p_rdata, dv, busy     : read byte, one-cycle completion pulse, busy flag
//   mem_address/mem_wdata/mem_wren/mem_rdata : RAM word port
//   hit_cnt, miss_cnt     : saturating hit/miss counters
module dm_cache_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_req,
  input  logic        p_wren,
  input  logic [8:0]  p_address,
  input  logic [7:0]  p_wdata,
  output logic [7:0]  p_rdata,
  output logic        dv,
  output logic        busy,
  output logic [6:0]  mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  hit_cnt,
  output logic [7:0]  miss_cnt
);

  localparam int unsigned LINES  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned LAT_W  = 3;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE} state_e;

  state_e                          state_q, state_d;
  logic [8:0]                      addr_q, addr_d;
  logic                            wren_q, wren_d;
  logic [7:0]                      wdata_q, wdata_d;
  logic [LAT_W-1:0]                lat_q, lat_d;
  logic [LINES-1:0]                valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]     tag_q, tag_d;
  logic [LINES-1:0][WORD_W-1:0]    data_q, data_d;
  logic                            dv_q, dv_d;
  logic                            busy_q, busy_d;
  logic [7:0]                      p_rdata_q, p_rdata_d;
  logic [6:0]                      mem_address_q, mem_address_d;
  logic [31:0]                     mem_wdata_q, mem_wdata_d;
  logic                            mem_wren_q, mem_wren_d;
  logic [7:0]                      hit_cnt_q, hit_cnt_d;
  logic [7:0]                      miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       sel;
  logic             line_hit;

  // Extract the selected byte lane from a word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] s);
    logic [7:0] b;
    case (s)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Replace the selected byte lane of a word.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] s,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (s)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  assign idx      = addr_q[4:2];
  assign tag      = addr_q[8:5];
  assign sel      = addr_q[1:0];
  assign line_hit = valid_q[idx] && (tag_q[idx] == tag);

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wren_d        = wren_q;
    wdata_d       = wdata_q;
    lat_d         = lat_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    data_d        = data_q;
    dv_d          = 1'b0;
    busy_d        = busy_q;
    p_rdata_d     = p_rdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wren_d    = 1'b0;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (p_req) begin
          addr_d  = p_address;
          wren_d  = p_wren;
          wdata_d = p_wdata;
          busy_d  = 1'b1;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (line_hit) begin
          hit_cnt_d = (hit_cnt_q == 8'hFF) ? hit_cnt_q : hit_cnt_q + 8'd1;
          if (wren_q) begin
            mem_wren_d    = 1'b1;
            mem_address_d = {tag, idx};
            mem_wdata_d   = put_byte(data_q[idx], sel, wdata_q);
            state_d       = S_WRITE;
          end else begin
            p_rdata_d = get_byte(data_q[idx], sel);
            dv_d      = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end
        end else begin
          miss_cnt_d    = (miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1;
          mem_address_d = {tag, idx};
          lat_d         = LAT_W'(MEM_LAT - 1);
          state_d       = S_FILL;
        end
      end

      S_FILL: begin
        if (lat_q == '0) begin
          // Write-through keeps lines clean, so a resident line is simply replaced.
          valid_d[idx] = 1'b1;
          tag_d[idx]   = tag;
          data_d[idx]  = mem_rdata;
          if (wren_q) begin
            mem_wren_d  = 1'b1;
            mem_wdata_d = put_byte(mem_rdata, sel, wdata_q);
            state_d     = S_WRITE;
          end else begin
            p_rdata_d = get_byte(mem_rdata, sel);
            dv_d      = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      S_WRITE: begin
        data_d[idx] = mem_wdata_q;
        dv_d        = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wren_q        <= 1'b0;
      wdata_q       <= '0;
      lat_q         <= '0;
      valid_q       <= '0;
      tag_q         <= '0;
      data_q        <= '0;
      dv_q          <= 1'b0;
      busy_q        <= 1'b0;
      p_rdata_q     <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_wren_q    <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wren_q        <= wren_d;
      wdata_q       <= wdata_d;
      lat_q         <= lat_d;
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      data_q        <= data_d;
      dv_q          <= dv_d;
      busy_q        <= busy_d;
      p_rdata_q     <= p_rdata_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wren_q    <= mem_wren_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign p_rdata     = p_rdata_q;
  assign dv          = dv_q;
  assign busy        = busy_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wren    = mem_wren_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl with a negedge-clocked RAM model.
module tb_dm_cache_ctrl;

  localparam int unsigned L = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req;
  logic        p_wren;
  logic [8:0]  p_address;
  logic [7:0]  p_wdata;
  logic [7:0]  p_rdata;
  logic        dv;
  logic        busy;
  logic [6:0]  mem_address;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic [31:0] mem_rdata;
  logic [7:0]  hit_cnt;
  logic [7:0]  miss_cnt;

  dm_cache_ctrl #(.MEM_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .p_req(p_req), .p_wren(p_wren),
    .p_address(p_address), .p_wdata(p_wdata), .p_rdata(p_rdata),
    .dv(dv), .busy(busy), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read on the inverted clock, write on the rising edge.
  logic [31:0] ram  [128];
  logic [31:0] gold [128];
  always @(negedge clk) mem_rdata <= ram[mem_address];
  always @(posedge clk) if (mem_wren) ram[mem_address] <= mem_wdata;

  typedef struct { int due; bit chk; logic [7:0] rd; } dv_exp_t;
  typedef struct { logic [6:0] a; logic [31:0] d; } wr_exp_t;
  dv_exp_t dv_exp[$];
  wr_exp_t wr_exp[$];

  // Reference cache state.
  bit          m_valid [8];
  logic [3:0]  m_tag   [8];
  int          m_hit  = 0;
  int          m_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on dv and on every RAM write.
  always @(negedge clk) begin
    if (dv) begin
      if (dv_exp.size() == 0) check("dv_spurious", 32'd1, 32'd0);
      else begin
        dv_exp_t e;
        e = dv_exp.pop_front();
        check("dv_cycle", cyc, e.due);
        if (e.chk) check("rdata", {24'd0, p_rdata}, {24'd0, e.rd});
      end
    end
    if (mem_wren) begin
      if (wr_exp.size() == 0) check("wren_spurious", 32'd1, 32'd0);
      else begin
        wr_exp_t w;
        w = wr_exp.pop_front();
        check("wr_addr", {25'd0, mem_address}, {25'd0, w.a});
        check("wr_data", mem_wdata, w.d);
      end
    end
  end

  task automatic issue(input bit wr, input logic [8:0] addr, input logic [7:0] wd,
                       input bit pulse);
    logic [6:0] w;
    logic [2:0] idx;
    logic [3:0] tg;
    int         sel;
    bit         hit;
    int         lat;
    int         acc;
    dv_exp_t    e;
    wr_exp_t    x;
    w   = addr[8:2];
    idx = addr[4:2];
    tg  = addr[8:5];
    sel = int'(addr[1:0]);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    lat = hit ? (wr ? 2 : 1) : (wr ? 2 + L : 1 + L);
    if (hit) m_hit = (m_hit < 255) ? m_hit + 1 : 255;
    else     m_miss = (m_miss < 255) ? m_miss + 1 : 255;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (wr) begin
      gold[w][sel*8 +: 8] = wd;
      x.a = w;
      x.d = gold[w];
      wr_exp.push_back(x);
    end
    @(negedge clk);
    p_req = 1'b1; p_wren = wr; p_address = addr; p_wdata = wd;
    @(posedge clk); #1;
    acc   = cyc;
    p_req = 1'b0;
    e.due = acc + lat;
    e.chk = !wr;
    e.rd  = gold[w][sel*8 +: 8];
    dv_exp.push_back(e);
    if (pulse) begin
      @(negedge clk);
      check("busy_during_op", {31'd0, busy}, 32'd1);
      p_req = 1'b1; p_wren = 1'b0; p_address = 9'h000;
      @(negedge clk);
      p_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dv_exp.size() == 0 && wr_exp.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", {31'd0, ok}, 32'd1);
    check("hit_cnt", {24'd0, hit_cnt}, 32'(m_hit));
    check("miss_cnt", {24'd0, miss_cnt}, 32'(m_miss));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dv"}, {31'd0, dv}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_wren"}, {31'd0, mem_wren}, 32'd0);
    check({tag, "_rdata"}, {24'd0, p_rdata}, 32'd0);
    check({tag, "_maddr"}, {25'd0, mem_address}, 32'd0);
    check({tag, "_mwdata"}, mem_wdata, 32'd0);
    check({tag, "_hits"}, {24'd0, hit_cnt}, 32'd0);
    check({tag, "_misses"}, {24'd0, miss_cnt}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pool [7];
    pool = '{5, 13, 21, 9, 2, 10, 29};
    for (int i = 0; i < 128; i++) begin
      logic [7:0] b;
      b = 8'(i);
      ram[i] = {b ^ 8'h5A, b, ~b, b + 8'h03};
    end
    ram[5]  = 32'h11223344;
    ram[13] = 32'h55667788;
    ram[9]  = 32'h00000000;
    for (int i = 0; i < 128; i++) gold[i] = ram[i];
    for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end

    rst_n = 1'b0; p_req = 1'b0; p_wren = 1'b0; p_address = '0; p_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    issue(1'b0, 9'h016, 8'h00, 1'b0); wait_idle();   // read miss -> 0x22
    issue(1'b0, 9'h014, 8'h00, 1'b0); wait_idle();   // read hit -> 0x44
    issue(1'b1, 9'h017, 8'hAB, 1'b0); wait_idle();   // write hit
    issue(1'b0, 9'h017, 8'h00, 1'b0); wait_idle();   // read hit -> 0xAB
    issue(1'b0, 9'h034, 8'h00, 1'b0); wait_idle();   // conflict: word 13
    issue(1'b0, 9'h014, 8'h00, 1'b0); wait_idle();   // word 5 again
    issue(1'b0, 9'h035, 8'h00, 1'b0); wait_idle();   // word 13 again
    issue(1'b1, 9'h024, 8'h5A, 1'b1); wait_idle();   // write miss + ignored req
    issue(1'b0, 9'h024, 8'h00, 1'b0); wait_idle();

    for (int n = 0; n < 40; n++) begin
      int k;
      logic [6:0] w;
      logic [1:0] s;
      k = int'($urandom_range(0, 6));
      w = 7'(pool[k]);
      s = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), {w, s}, 8'($urandom), 1'b0);
      wait_idle();
    end

    // Abort a fill with reset.
    @(negedge clk);
    p_req = 1'b1; p_wren = 1'b0; p_address = 9'h190;
    @(posedge clk); #1 p_req = 1'b0;
    @(posedge clk); #1;
    check("fill_busy", {31'd0, busy}, 32'd1);
    check("fill_addr", {25'd0, mem_address}, 32'd100);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hit = 0; m_miss = 0;
    repeat (8) @(negedge clk);
    check("abort_no_dv_pending", 32'(dv_exp.size()), 32'd0);

    issue(1'b0, 9'h014, 8'h00, 1'b0); wait_idle();   // previously cached -> miss
    for (int n = 0; n < 260; n++) begin
      issue(1'b0, 9'h014, 8'h00, 1'b0);
      wait_idle();
    end
    check("hit_sat", {24'd0, hit_cnt}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
